// File: rtl/posizione_quadrato.sv
// Square-position controller: owns the square's centre (X_POS, Y_POS) and
// moves it once per frame from four push buttons. It accelerates after a run
// of consecutive moving frames. X wraps modulo H and Y is clamped to keep the
// square on screen. Outputs change only on the edge that follows FRAME_TICK.
//
// Ports:
//   CLK, RESET          pixel clock, synchronous active-high reset
//   FRAME_TICK          1-cycle pulse at vblank start
//   BTN_SX/DX/SU/GIU    asynchronous level buttons: left/right/up/down
//   DEMO                (POS_DEMO_EN only) asynchronous demo-mode enable
//   X_POS, Y_POS        registered centre coordinates (11 bits)
//   AGGIORNATO          1-cycle pulse when the position changed this frame
//
// Optional feature: define POS_DEMO_EN to add the DEMO input. In demo mode the
// square is bounced vertically while it scrolls right.
module posizione_quadrato #(
    parameter int unsigned H          = 1280,
    parameter int unsigned V          = 1024,
    parameter int unsigned ALTEZZA    = 100,
    parameter int unsigned X_INIT     = 640,
    parameter int unsigned Y_INIT     = 512,
    parameter int unsigned PASSO      = 4,
    parameter int unsigned PASSO_MAX  = 16,
    parameter int unsigned ACC_FRAMES = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        FRAME_TICK,
    input  logic        BTN_SX,
    input  logic        BTN_DX,
    input  logic        BTN_SU,
    input  logic        BTN_GIU,
`ifdef POS_DEMO_EN
    input  logic        DEMO,
`endif
    output logic [10:0] X_POS,
    output logic [10:0] Y_POS,
    output logic        AGGIORNATO
);

    localparam int unsigned PW = 11;
    localparam int unsigned AW = 12;
    localparam int unsigned CW = $clog2(ACC_FRAMES + 1);

    localparam logic [AW-1:0] H_A      = AW'(H);
    localparam logic [AW-1:0] YMIN_A   = AW'(ALTEZZA / 2);
    localparam logic [AW-1:0] YMAX_A   = AW'(V - ALTEZZA / 2);
    localparam logic [AW-1:0] PASSO_A  = AW'(PASSO);
    localparam logic [AW-1:0] PMAX_A   = AW'(PASSO_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACC_FRAMES - 1);

    typedef enum logic [1:0] {FERMO, AVVIO, VELOCE} stato_t;

    // Synchronizers, order {GIU, SU, DX, SX}
    logic [3:0]    btn_meta_q, btn_sync_q;
    stato_t        state_q, state_d;
    logic [AW-1:0] vel_q, vel_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] x_q, x_d, y_q, y_d;
    logic          agg_q, agg_d;

    // Move request for this frame: speed and one-hot-ish direction flags
    logic [AW-1:0] step;
    logic          go_r, go_l, go_d, go_u, moving;

`ifdef POS_DEMO_EN
    logic demo_meta_q, demo_sync_q;
    logic demo_prev_q, demo_prev_d;
    logic dir_y_q, dir_y_d;
`endif

    // State register: synchronizers, FSM, speed, position
    always_ff @(posedge CLK) begin
        if (RESET) begin
            btn_meta_q <= '0;
            btn_sync_q <= '0;
            state_q    <= FERMO;
            vel_q      <= '0;
            cnt_q      <= '0;
            x_q        <= PW'(X_INIT);
            y_q        <= PW'(Y_INIT);
            agg_q      <= 1'b0;
`ifdef POS_DEMO_EN
            demo_meta_q <= 1'b0;
            demo_sync_q <= 1'b0;
            demo_prev_q <= 1'b0;
            dir_y_q     <= 1'b1;
`endif
        end else begin
            btn_meta_q <= {BTN_GIU, BTN_SU, BTN_DX, BTN_SX};
            btn_sync_q <= btn_meta_q;
            state_q    <= state_d;
            vel_q      <= vel_d;
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            agg_q      <= agg_d;
`ifdef POS_DEMO_EN
            demo_meta_q <= DEMO;
            demo_sync_q <= demo_meta_q;
            demo_prev_q <= demo_prev_d;
            dir_y_q     <= dir_y_d;
`endif
        end
    end

    // Next-state: FSM, speed profile and the move requested this frame
    always_comb begin
        logic [AW-1:0] vel_sum;
        state_d = state_q;
        vel_d   = vel_q;
        cnt_d   = cnt_q;
        step    = '0;
        // Opposite buttons cancel each other
        go_l    = btn_sync_q[0] & ~btn_sync_q[1];
        go_r    = btn_sync_q[1] & ~btn_sync_q[0];
        go_u    = btn_sync_q[2] & ~btn_sync_q[3];
        go_d    = btn_sync_q[3] & ~btn_sync_q[2];
        moving  = go_l | go_r | go_u | go_d;
        vel_sum = vel_q + PASSO_A;
`ifdef POS_DEMO_EN
        demo_prev_d = demo_prev_q;
`endif
        if (FRAME_TICK) begin
            case (state_q)
                FERMO: begin
                    if (moving) begin
                        state_d = AVVIO;
                        vel_d   = PASSO_A;
                        cnt_d   = CW'(1);
                        step    = PASSO_A;
                    end else begin
                        vel_d = '0;
                    end
                end
                AVVIO: begin
                    if (!moving) begin
                        state_d = FERMO;
                        vel_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        if (cnt_q == CNT_LAST) state_d = VELOCE;
                        else                   cnt_d   = cnt_q + CW'(1);
                        step = vel_q;
                    end
                end
                VELOCE: begin
                    if (!moving) begin
                        state_d = FERMO;
                        vel_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        vel_d = (vel_sum > PMAX_A) ? PMAX_A : vel_sum;
                        step  = vel_d;
                    end
                end
                default: begin
                    state_d = FERMO;
                    vel_d   = '0;
                    cnt_d   = '0;
                end
            endcase
`ifdef POS_DEMO_EN
            demo_prev_d = demo_sync_q;
            if (demo_sync_q) begin
                // Demo overrides buttons: scroll right, bounce vertically
                state_d = AVVIO;
                vel_d   = PASSO_A;
                cnt_d   = cnt_q;
                step    = PASSO_A;
                go_r    = 1'b1;
                go_l    = 1'b0;
                go_d    = dir_y_q;
                go_u    = ~dir_y_q;
            end else if (demo_prev_q) begin
                // Leaving demo: stop dead for this frame
                state_d = FERMO;
                vel_d   = '0;
                cnt_d   = '0;
                step    = '0;
            end
`endif
        end
    end

    // Outputs: wrapped X, clamped Y, change flag
    always_comb begin
        logic [AW-1:0] x_w, y_w, s_w, nx, ny;
        x_w = AW'(x_q);
        y_w = AW'(y_q);
        s_w = x_w + step;
        nx  = x_w;
        ny  = y_w;
        if (go_r)      nx = (s_w >= H_A) ? s_w - H_A : s_w;
        else if (go_l) nx = (x_w < step) ? x_w + H_A - step : x_w - step;
        // Underflow tested before subtracting so Y never goes negative
        if (go_d)      ny = ((y_w + step) > YMAX_A) ? YMAX_A : y_w + step;
        else if (go_u) ny = (y_w < (YMIN_A + step)) ? YMIN_A : y_w - step;

        x_d   = x_q;
        y_d   = y_q;
        agg_d = 1'b0;
        if (FRAME_TICK) begin
            x_d   = PW'(nx);
            y_d   = PW'(ny);
            agg_d = (x_d != x_q) || (y_d != y_q);
        end
`ifdef POS_DEMO_EN
        dir_y_d = dir_y_q;
        if (FRAME_TICK && demo_sync_q) begin
            if (ny == YMAX_A)      dir_y_d = 1'b0;
            else if (ny == YMIN_A) dir_y_d = 1'b1;
        end
`endif
    end

    assign X_POS      = x_q;
    assign Y_POS      = y_q;
    assign AGGIORNATO = agg_q;

endmodule
